// File: rtl/shift_sequencer.sv
// shift_sequencer: parallel-in / serial-out sequencer.
// A one-word holding register decouples the producer handshake from the
// serializer. Words are shifted out MSB first. Each bit is flagged with
// first/last markers. Optional idle gap cycles separate words.
module shift_sequencer #(
  parameter int WIDTH = 4,
  parameter int GAP   = 0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] I_DATA,
  input  logic             I_VALID,
  output logic             I_READY,
  input  logic             STALL,
  output logic             SER_O,
  output logic             SER_VALID,
  output logic             SER_FIRST,
  output logic             SER_LAST,
  output logic             BUSY,
  output logic             DONE
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP > 0) ? GAP_W'(GAP - 1) : '0;

  typedef enum logic [1:0] {IDLE, SHIFT, GAPW} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [WIDTH-1:0]   hold_data_q, hold_data_d;
  logic               hold_valid_q, hold_valid_d;
  logic               done_q, done_d;

  // State register: every flop updates together; reset drops both words in flight.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      cnt_q        <= '0;
      gap_q        <= '0;
      hold_data_q  <= '0;
      hold_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      gap_q        <= gap_d;
      hold_data_q  <= hold_data_d;
      hold_valid_q <= hold_valid_d;
      done_q       <= done_d;
    end
  end

  // Next-state logic: producer accept, shifting, gap timing, and hold-to-shifter load.
  always_comb begin
    logic load;
    state_d      = state_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    gap_d        = gap_q;
    hold_data_d  = hold_data_q;
    hold_valid_d = hold_valid_q;
    done_d       = 1'b0;
    load         = 1'b0;

    // Accept only into an empty hold, so an accept never coincides with a load.
    if (I_VALID && !hold_valid_q) begin
      hold_data_d  = I_DATA;
      hold_valid_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        load = hold_valid_q;
      end
      SHIFT: begin
        if (!STALL) begin
          if (cnt_q != '0) begin
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            cnt_d   = cnt_q - 1'b1;
          end else begin
            done_d = 1'b1;
            if (GAP > 0) begin
              state_d = GAPW;
              gap_d   = GAP_LOAD;
            end else if (hold_valid_q) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      GAPW: begin
        if (gap_q == '0) begin
          if (hold_valid_q) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // The hold is only read when it was already full before this edge.
    if (load) begin
      shreg_d      = hold_data_q;
      cnt_d        = CNT_MAX;
      hold_valid_d = 1'b0;
      state_d      = SHIFT;
    end
  end

  // Output decode: serial flags come from registered state only.
  always_comb begin
    SER_VALID = (state_q == SHIFT);
    SER_O     = SER_VALID && shreg_q[WIDTH-1];
    SER_FIRST = SER_VALID && (cnt_q == CNT_MAX);
    SER_LAST  = SER_VALID && (cnt_q == '0);
    BUSY      = (state_q != IDLE) || hold_valid_q;
    I_READY   = !hold_valid_q;
    DONE      = done_q;
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Testbench for shift_sequencer. Two instances run side by side on shared inputs:
// one with GAP=0 and one with GAP=2.
// Both instances are compared with a word-level reference model. Table vectors
// and hand-written sequences cover the multi-cycle cases.
module tb_shift_sequencer;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_valid = 1'b0;
  logic [W-1:0] i_data = '0;
  logic stall = 1'b0;

  logic rdy0, so0, sv0, first0, last0, busy0, done0;
  logic rdy2, so2, sv2, first2, last2, busy2, done2;

  always #5 clk = ~clk;

  shift_sequencer #(.WIDTH(W), .GAP(0)) dut_g0 (
    .CLK(clk), .RESET(rst), .I_DATA(i_data), .I_VALID(i_valid), .I_READY(rdy0),
    .STALL(stall), .SER_O(so0), .SER_VALID(sv0), .SER_FIRST(first0),
    .SER_LAST(last0), .BUSY(busy0), .DONE(done0)
  );

  shift_sequencer #(.WIDTH(W), .GAP(2)) dut_g2 (
    .CLK(clk), .RESET(rst), .I_DATA(i_data), .I_VALID(i_valid), .I_READY(rdy2),
    .STALL(stall), .SER_O(so2), .SER_VALID(sv2), .SER_FIRST(first2),
    .SER_LAST(last2), .BUSY(busy2), .DONE(done2)
  );

  // Packed output views: {ready, busy, done, valid, ser_o, first, last}
  wire [6:0] out0 = {rdy0, busy0, done0, sv0, so0, first0, last0};
  wire [6:0] out2 = {rdy2, busy2, done2, sv2, so2, first2, last2};

  // Reference model. It tracks bits remaining in the current word, gap cycles
  // remaining, and the held word (-1 when empty).
  typedef struct {
    int       left;
    int       gap;
    int       hold;
    logic [W-1:0] word;
    bit       done;
  } mdl_t;

  mdl_t m0 = '{0, 0, -1, '0, 1'b0};
  mdl_t m2 = '{0, 0, -1, '0, 1'b0};

  function automatic mdl_t mdl_step(mdl_t m, int gap_cfg, bit r, bit v, logic [W-1:0] d, bit st);
    mdl_t n = m;
    bit load = 1'b0;
    n.done = 1'b0;
    if (r) begin
      n.left = 0; n.gap = 0; n.hold = -1; n.word = '0;
      return n;
    end
    if (m.left > 0) begin
      if (!st) begin
        n.left = m.left - 1;
        if (n.left == 0) begin
          n.done = 1'b1;
          if (gap_cfg > 0) n.gap = gap_cfg;
          else load = 1'b1;
        end
      end
    end else if (m.gap > 0) begin
      n.gap = m.gap - 1;
      if (n.gap == 0) load = 1'b1;
    end else begin
      load = 1'b1;
    end
    if (load && m.hold >= 0) begin
      n.word = m.hold[W-1:0];
      n.left = W;
      n.hold = -1;
    end
    if (v && m.hold < 0) n.hold = int'(d);
    return n;
  endfunction

  function automatic logic [6:0] mdl_out(mdl_t m);
    logic sv, so;
    sv = (m.left > 0);
    so = sv ? m.word[m.left-1] : 1'b0;
    return {m.hold < 0, (m.left > 0) || (m.gap > 0) || (m.hold >= 0), m.done,
            sv, so, m.left == W, m.left == 1};
  endfunction

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One clock edge. The models see the same inputs the DUTs sampled.
  task automatic tick();
    @(posedge clk);
    m0 = mdl_step(m0, 0, rst, i_valid, i_data, stall);
    m2 = mdl_step(m2, 2, rst, i_valid, i_data, stall);
    #1;
  endtask

  task automatic check_models(string tag);
    chk({tag, "_g0_model"}, int'(out0), int'(mdl_out(m0)));
    chk({tag, "_g2_model"}, int'(out2), int'(mdl_out(m2)));
  endtask

  task automatic do_reset();
    rst = 1'b1; i_valid = 1'b0; stall = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    bit r;
    bit v;
    logic [W-1:0] d;
    bit st;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[$];
  logic bits[$];

  initial begin
    // Single word 1011, followed by back-to-back words 1100 and 0011 (GAP=0 instance).
    vecs.push_back('{1'b1, 1'b0, 4'b0000, 1'b0, 7'b1000000});
    vecs.push_back('{1'b0, 1'b1, 4'b1011, 1'b0, 7'b0100000});
    vecs.push_back('{1'b0, 1'b0, 4'b0000, 1'b0, 7'b1101110});
    vecs.push_back('{1'b0, 1'b0, 4'b0000, 1'b0, 7'b1101000});
    vecs.push_back('{1'b0, 1'b0, 4'b0000, 1'b0, 7'b1101100});
    vecs.push_back('{1'b0, 1'b0, 4'b0000, 1'b0, 7'b1101101});
    vecs.push_back('{1'b0, 1'b0, 4'b0000, 1'b0, 7'b1010000});
    vecs.push_back('{1'b0, 1'b0, 4'b0000, 1'b0, 7'b1000000});
    vecs.push_back('{1'b1, 1'b0, 4'b0000, 1'b0, 7'b1000000});
    vecs.push_back('{1'b0, 1'b1, 4'b1100, 1'b0, 7'b0100000});
    vecs.push_back('{1'b0, 1'b1, 4'b0011, 1'b0, 7'b1101110});
    vecs.push_back('{1'b0, 1'b1, 4'b0011, 1'b0, 7'b0101100});
    vecs.push_back('{1'b0, 1'b0, 4'b0000, 1'b0, 7'b0101000});
    vecs.push_back('{1'b0, 1'b0, 4'b0000, 1'b0, 7'b0101001});
    vecs.push_back('{1'b0, 1'b0, 4'b0000, 1'b0, 7'b1111010});
    vecs.push_back('{1'b0, 1'b0, 4'b0000, 1'b0, 7'b1101000});
    vecs.push_back('{1'b0, 1'b0, 4'b0000, 1'b0, 7'b1101100});
    vecs.push_back('{1'b0, 1'b0, 4'b0000, 1'b0, 7'b1101101});
    vecs.push_back('{1'b0, 1'b0, 4'b0000, 1'b0, 7'b1010000});
    vecs.push_back('{1'b0, 1'b0, 4'b0000, 1'b0, 7'b1000000});

    rst = 1'b1;
    tick();
    tick();

    // Table vectors
    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].r; i_valid = vecs[i].v; i_data = vecs[i].d; stall = vecs[i].st;
      tick();
      chk($sformatf("vec%0d", i), int'(out0), int'(vecs[i].exp));
      chk($sformatf("vec%0d_g2_model", i), int'(out2), int'(mdl_out(m2)));
      $display("vec %0d: r=%0b v=%0b d=%b st=%0b -> out0=%b exp=%b",
               i, vecs[i].r, vecs[i].v, vecs[i].d, vecs[i].st, out0, vecs[i].exp);
    end

    // Stall for 3 edges while bit 2 of 0110 is presented
    begin
      int done_cnt = 0;
      int done_at = -1;
      logic [6:0] exp_bits;
      do_reset();
      i_valid = 1'b1; i_data = 4'b0110;
      tick();
      i_valid = 1'b0;
      bits.delete();
      for (int t = 1; t <= 12; t++) begin
        stall = (t >= 3 && t <= 5);
        tick();
        if (sv0) bits.push_back(so0);
        if (done0) begin done_cnt++; done_at = t; end
        check_models("stall");
      end
      stall = 1'b0;
      exp_bits = 7'b0111110;
      chk("stall_len", bits.size(), 7);
      for (int i = 0; i < 7 && i < bits.size(); i++)
        chk($sformatf("stall_bit%0d", i), int'(bits[i]), int'(exp_bits[6-i]));
      chk("stall_done_cnt", done_cnt, 1);
      chk("stall_done_at", done_at, 8);
      $display("stall seq: %0d valid bits, done at edge %0d", bits.size(), done_at);
    end

    // Reset during bit 1 of a word with a second word held
    begin
      int done_cnt = 0;
      int first_idx = -1;
      int last_idx = -1;
      logic [3:0] exp_c;
      do_reset();
      i_valid = 1'b1; i_data = 4'b1001; tick();
      i_valid = 1'b0; tick();
      i_valid = 1'b1; i_data = 4'b0101; tick();
      i_valid = 1'b0; tick();
      chk("rst_pre_valid", int'(sv0), 1);
      chk("rst_pre_ready", int'(rdy0), 0);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("rst_outputs", int'(out0), int'(7'b1000000));
      check_models("rst");
      for (int t = 0; t < 3; t++) begin
        tick();
        chk("rst_no_done", int'(out0), int'(7'b1000000));
      end
      i_valid = 1'b1; i_data = 4'b1010; tick();
      i_valid = 1'b0;
      bits.delete();
      for (int t = 0; t < 8; t++) begin
        tick();
        if (sv0) begin
          if (first0) first_idx = bits.size();
          if (last0) last_idx = bits.size();
          bits.push_back(so0);
        end
        if (done0) done_cnt++;
        check_models("rst_after");
      end
      exp_c = 4'b1010;
      chk("rst_after_len", bits.size(), 4);
      for (int i = 0; i < 4 && i < bits.size(); i++)
        chk($sformatf("rst_after_bit%0d", i), int'(bits[i]), int'(exp_c[3-i]));
      chk("rst_after_first", first_idx, 0);
      chk("rst_after_last", last_idx, 3);
      chk("rst_after_done", done_cnt, 1);
      $display("reset seq: next word produced %0d bits, %0d done", bits.size(), done_cnt);
    end

    // Full hold with I_VALID high: no overwrite of the held word
    begin
      logic [7:0] exp_h;
      do_reset();
      i_valid = 1'b1; i_data = 4'b1110; tick();
      bits.delete();
      for (int t = 1; t <= 12; t++) begin
        i_valid = (t <= 5);
        i_data = (t <= 2) ? 4'b1001 : 4'b0110;
        tick();
        if (sv0) bits.push_back(so0);
        if (t >= 2 && t <= 4) chk($sformatf("hold_ready_t%0d", t), int'(rdy0), 0);
        check_models("hold");
      end
      i_valid = 1'b0;
      exp_h = 8'b1110_1001;
      chk("hold_len", bits.size(), 8);
      for (int i = 0; i < 8 && i < bits.size(); i++)
        chk($sformatf("hold_bit%0d", i), int'(bits[i]), int'(exp_h[7-i]));
      $display("hold seq: %0d bits serialized", bits.size());
    end

    // Two words on the GAP=2 instance: idle cycles between them
    begin
      logic [3:0] words[$];
      int idle_run = 0;
      bit seen_last = 1'b0;
      int gap_len = -1;
      logic [7:0] exp_g;
      logic pre_ready;
      do_reset();
      words.push_back(4'b1111);
      words.push_back(4'b1010);
      bits.delete();
      for (int t = 0; t < 30; t++) begin
        i_valid = (words.size() > 0);
        i_data = (words.size() > 0) ? words[0] : 4'b0000;
        pre_ready = rdy2;
        tick();
        if (i_valid && pre_ready) void'(words.pop_front());
        check_models("gap");
        if (sv2) bits.push_back(so2);
        if (sv2 && first2 && seen_last && gap_len < 0) gap_len = idle_run;
        if (sv2 && last2) seen_last = 1'b1;
        if (!sv2 && seen_last && gap_len < 0) idle_run++;
      end
      i_valid = 1'b0;
      exp_g = 8'b1111_1010;
      chk("gap_len", gap_len, 2);
      chk("gap_bits_len", bits.size(), 8);
      for (int i = 0; i < 8 && i < bits.size(); i++)
        chk($sformatf("gap_bit%0d", i), int'(bits[i]), int'(exp_g[7-i]));
      $display("gap seq: %0d idle cycles between words", gap_len);
    end

    // Random stimulus against the model
    do_reset();
    for (int t = 0; t < 3000; t++) begin
      rst = ($urandom_range(0, 99) == 0);
      i_valid = ($urandom_range(0, 9) < 6);
      i_data = W'($urandom);
      stall = ($urandom_range(0, 9) < 2);
      tick();
      check_models($sformatf("rand%0d", t));
    end
    $display("random: 3000 cycles compared");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Parallel-in/serial-out sequencer for the DFF shift-register datapath.
- Accepts WIDTH-bit words over a valid/ready handshake and buffers one word in a holding register.
- Shifts each word out MSB-first, one bit per cycle, with framing flags, optional inter-word gap cycles and a stall input.
- Sits between a word-oriented producer and a serial consumer.

Parameters:
- WIDTH, 4, bits per word; legal range WIDTH >= 2.
- GAP, 0, number of idle cycles (SER_VALID=0) inserted after each word; legal range GAP >= 0.

Ports:
- CLK  input  1  single clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- I_DATA  input  WIDTH  parallel word to serialize.
- I_VALID  input  1  producer has a word on I_DATA.
- I_READY  output  1  holding register empty; a word is accepted on an edge where I_VALID && I_READY.
- STALL  input  1  freezes shifting while in SHIFT.
- SER_O  output  1  serial data bit, MSB first.
- SER_VALID  output  1  SER_O carries a data bit this cycle.
- SER_FIRST  output  1  current bit is bit WIDTH-1 of its word.
- SER_LAST  output  1  current bit is bit 0 of its word.
- BUSY  output  1  state != IDLE or holding register full.
- DONE  output  1  one-cycle pulse after the last bit of a word is consumed.

Behaviour:
- Clock and reset: one clock, CLK. RESET is synchronous and active-high.
- Internal state: state {IDLE, SHIFT, GAPW}, shreg[WIDTH], bit counter cnt (clog2(WIDTH) bits), gap counter, hold_data, hold_valid.
- On an edge with RESET=1:
  - state=IDLE, hold_valid=0, shreg=0, cnt=0, gap counter=0, DONE=0.
  - Resulting outputs: SER_O=0, SER_VALID=0, SER_FIRST=0, SER_LAST=0, BUSY=0, I_READY=1.
  - RESET mid-word discards the word in flight and the held word; no DONE is produced.
- I_READY = !hold_valid (combinational).
  - On accept: hold_data<=I_DATA, hold_valid<=1.
  - When the hold is full, I_READY=0 and I_DATA/I_VALID are ignored.
- IDLE:
  - SER_VALID=0.
  - If hold_valid: shreg<=hold_data, hold_valid<=0, cnt<=WIDTH-1, go to SHIFT.
  - Latency: accept edge k; load at edge k+1; first bit visible in the cycle after edge k+1.
- SHIFT:
  - Outputs: SER_VALID=1, SER_O=shreg[WIDTH-1], SER_FIRST=(cnt==WIDTH-1), SER_LAST=(cnt==0).
  - STALL=1: shreg, cnt and state hold. Outputs remain stable. Accepts into the hold are still allowed.
  - STALL=0 and cnt!=0: shreg shifts left with 0 fill; cnt decrements.
  - STALL=0 and cnt==0 (word complete): DONE<=1 for exactly one cycle, then:
    - If GAP>0: go to GAPW with gap counter<=GAP-1.
    - Else if hold_valid: load the next word and stay in SHIFT. This gives back-to-back bits with no bubble.
    - Else: go to IDLE.
- GAPW:
  - SER_VALID=0; STALL ignored.
  - Gap counter decrements each edge.
  - At gap counter==0: load from the hold into SHIFT if hold_valid, else go to IDLE.
  - Exactly GAP non-valid cycles separate consecutive words.
- Simultaneity: a load from the hold and a new accept never coincide on one edge, because accept requires an empty hold. A word accepted on the same edge the last bit completes is loaded at the next eligible edge, never earlier.
- SER_FIRST and SER_LAST are both meaningful only while SER_VALID=1 and are 0 otherwise.
- Outputs SER_FIRST, SER_LAST and SER_VALID are derived from registered state only; no combinational path from I_DATA to SER_*.

Test Plan:
- WIDTH=4, GAP=0: accept 4'b1011 at edge 0 -> SER_VALID cycles 2..5 with SER_O=1,0,1,1; SER_FIRST in cycle 2, SER_LAST in cycle 5; DONE=1 in cycle 6 only; BUSY=0 in cycle 6 or later.
- Back-to-back, GAP=0: 4'b1100 then 4'b0011 offered continuously -> 8 consecutive SER_VALID cycles with bits 1,1,0,0,0,0,1,1. I_READY drops while the hold is full. Exactly two DONE pulses.
- GAP=2: two words 4'b1111 then 4'b1010 -> exactly 2 SER_VALID=0 cycles between SER_LAST of word 1 and SER_FIRST of word 2.
- STALL=1 for 3 cycles while bit 2 of 4'b0110 is presented -> SER_O=1 held for 4 cycles total, then 1,0 follow; total word duration 7 cycles; DONE unaffected except delayed.
- RESET=1 for one edge during bit 1 of a word, with a second word held -> all outputs 0 and I_READY=1 next cycle. No DONE. The next accepted word serializes normally from its MSB.
- I_VALID held high with a full hold during SHIFT -> I_READY=0 and no overwrite. The held word appears intact after the current word.
